// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the parametrised data memory.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package data_mem_pkg;

  typedef enum logic {
    MEM_INIT = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

  // Widest word the byte-merge helper handles; callers zero-extend into it.
  localparam int MERGE_MAX_W  = 256;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  // Byte-lane merge: lanes with be set take new_word, the rest keep old_word.
  // Shared by the storage write and the write-first read forward so the
  // two paths can never disagree.
  function automatic logic [MERGE_MAX_W-1:0] be_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/param_data_mem.sv
// Word-addressed data memory with byte enables, write-first forwarding and a post-reset clear sweep.
// Latency: reads return exactly one cycle after the request; writes land at the request edge.
// Backpressure: none per request; mem_ready stays low for DEPTH cycles after reset while contents are cleared.
module param_data_mem
  import data_mem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 8,
  parameter int                ADDR_W   = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_wr_en,
  input  logic [ADDR_W-1:0]    mem_wr_addr,
  input  logic [DATA_W-1:0]    mem_wr_data,
  input  logic [DATA_W/8-1:0]  mem_wr_be,
  input  logic                 mem_rd_en,
  input  logic [ADDR_W-1:0]    mem_rd_addr,
  output logic [DATA_W-1:0]    mem_rd_data,
  output logic                 mem_rd_valid,
  output logic                 mem_ready,
  output logic                 mem_addr_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  // Range checks compare in ADDR_W+1 bits so DEPTH itself is always representable.
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  mem_state_e        state;
  logic [IDX_W-1:0]  init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic              fwd_hit;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_word;

  // Request decode: range check first, index only with the low bits of an in-range address.
  always_comb begin
    run         = (state == MEM_RUN);
    wr_in_range = ({1'b0, mem_wr_addr} < DEPTH_X);
    rd_in_range = ({1'b0, mem_rd_addr} < DEPTH_X);
    wr_idx      = wr_in_range ? mem_wr_addr[IDX_W-1:0] : '0;
    rd_idx      = rd_in_range ? mem_rd_addr[IDX_W-1:0] : '0;
    wr_ok       = run && mem_wr_en && wr_in_range;
    wr_merged   = DATA_W'(be_merge(MERGE_MAX_W'(mem[wr_idx]),
                                   MERGE_MAX_W'(mem_wr_data),
                                   MERGE_MAX_BE'(mem_wr_be)));
    // Same-cycle write to the read address: return the merged word (write-first).
    fwd_hit     = wr_ok && rd_in_range && (wr_idx == rd_idx);
    rd_word     = fwd_hit ? wr_merged : mem[rd_idx];
  end

  // Control: clear-sweep sequencing, registered read port and sticky range error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MEM_INIT;
      init_ptr     <= '0;
      mem_rd_data  <= '0;
      mem_rd_valid <= 1'b0;
      mem_ready    <= 1'b0;
      mem_addr_err <= 1'b0;
    end else begin
      mem_rd_valid <= 1'b0;
      if (state == MEM_INIT) begin
        init_ptr <= init_ptr + IDX_W'(1);
        if (init_ptr == LAST_IDX) begin
          state     <= MEM_RUN;
          mem_ready <= 1'b1;
        end
      end else begin
        if (mem_rd_en) begin
          mem_rd_valid <= 1'b1;
          mem_rd_data  <= rd_in_range ? rd_word : '0;
        end
        if ((mem_wr_en && !wr_in_range) || (mem_rd_en && !rd_in_range)) begin
          mem_addr_err <= 1'b1;
        end
      end
    end
  end

  // Storage: swept to INIT_VAL after reset, then byte-merged writes; untouched while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == MEM_INIT) begin
        mem[init_ptr] <= INIT_VAL;
      end else if (wr_ok) begin
        mem[wr_idx] <= wr_merged;
      end
    end
  end

endmodule

// File: tb/tb_param_data_mem.sv
// Randomised scoreboard bench for param_data_mem (DATA_W=16, DEPTH=8).
// Stimulus pushes expected read data into a queue; a negedge monitor pops on each valid strobe.
// Reset/sweep timing and the sticky error flag are checked from the stimulus thread.
module tb_param_data_mem;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_wr_en = 1'b0;
  logic [ADDR_W-1:0] mem_wr_addr = '0;
  logic [DATA_W-1:0] mem_wr_data = '0;
  logic [1:0]        mem_wr_be = '0;
  logic              mem_rd_en = 1'b0;
  logic [ADDR_W-1:0] mem_rd_addr = '0;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              mem_ready;
  logic              mem_addr_err;

  always #5 clk = ~clk;

  param_data_mem #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INIT_VAL('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_be   (mem_wr_be),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .mem_ready   (mem_ready),
    .mem_addr_err(mem_addr_err)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model[DEPTH];
  bit          model_run = 1'b0;
  bit          err_exp = 1'b0;
  bit          mon_en = 1'b0;
  logic        rst_seen = 1'b0;
  logic [15:0] last_data = '0;
  logic [15:0] popped;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Monitor: reset state, scoreboard pops on valid, data hold otherwise.
  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        check("reset_rd_valid", 32'(mem_rd_valid), 32'd0);
        check("reset_rd_data", 32'(mem_rd_data), 32'd0);
        last_data = '0;
      end else if (mem_rd_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rd_valid: got strobe with data %0h, required no strobe", mem_rd_data);
        end else begin
          popped = exp_q.pop_front();
          check("rd_data", 32'(mem_rd_data), 32'(popped));
        end
        last_data = mem_rd_data;
      end else begin
        check("rd_hold", 32'(mem_rd_data), 32'(last_data));
      end
    end
  end

  task automatic idle();
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0; mem_wr_be = '0;
    mem_rd_en = 1'b0; mem_rd_addr = '0;
  endtask

  // Requests during the sweep must all be ignored, including out-of-range ones.
  task automatic junk();
    mem_wr_en = 1'b1; mem_wr_addr = 16'($urandom_range(0, 15));
    mem_wr_data = 16'($urandom); mem_wr_be = 2'($urandom);
    mem_rd_en = 1'b1; mem_rd_addr = 16'($urandom_range(0, 15));
  endtask

  // One request cycle; model applies write first, then computes the read.
  task automatic issue(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input bit re, input logic [15:0] ra);
    @(posedge clk); #1;
    check("addr_err", 32'(mem_addr_err), 32'(err_exp));
    check("ready", 32'(mem_ready), 32'(model_run));
    mem_wr_en = we; mem_wr_addr = wa; mem_wr_data = wd; mem_wr_be = be;
    mem_rd_en = re; mem_rd_addr = ra;
    if (model_run) begin
      if (we) begin
        if (wa < DEPTH) begin
          for (int b = 0; b < 2; b++)
            if (be[b]) model[wa[2:0]][8*b +: 8] = wd[8*b +: 8];
        end else begin
          err_exp = 1'b1;
        end
      end
      if (re) begin
        if (ra < DEPTH) exp_q.push_back(model[ra[2:0]]);
        else begin
          exp_q.push_back(16'h0000);
          err_exp = 1'b1;
        end
      end
    end
  endtask

  task automatic flush();
    repeat (3) issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic apply_reset(input int hold, input int abort_at);
    int cnt;
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    model_run = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("reset_ready", 32'(mem_ready), 32'd0);
    check("reset_addr_err", 32'(mem_addr_err), 32'd0);
    rst = 1'b0;
    junk();
    if (abort_at > 0) begin
      repeat (abort_at) begin
        @(posedge clk); #1;
        junk();
      end
      check("ready_mid_init", 32'(mem_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("ready_in_reset", 32'(mem_ready), 32'd0);
      rst = 1'b0;
      junk();
    end
    cnt = 0;
    while (mem_ready !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (mem_ready !== 1'b1) junk();
    end
    idle();
    check("ready_latency", 32'(cnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    err_exp = 1'b0;
    model_run = 1'b1;
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 9) return 16'h8000 | 16'($urandom_range(0, 7));
    return 16'(r);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] wa;
    logic [15:0] ra;
    idle();
    apply_reset(2, 0);

    for (int a = 0; a < DEPTH; a++) issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'(a));
    issue(1'b1, 16'd3, 16'hBEEF, 2'b11, 1'b0, 16'h0);
    issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'd3);
    issue(1'b1, 16'd3, 16'h1234, 2'b01, 1'b0, 16'h0);
    issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'd3);
    issue(1'b1, 16'd5, 16'hA5A5, 2'b11, 1'b1, 16'd5);
    issue(1'b1, 16'd5, 16'h1200, 2'b10, 1'b1, 16'd5);
    issue(1'b1, 16'd6, 16'h7777, 2'b00, 1'b1, 16'd6);
    flush();
    issue(1'b1, 16'd8, 16'hFFFF, 2'b11, 1'b0, 16'h0);
    issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'd8);
    issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'd0);
    issue(1'b1, 16'h0103, 16'h7777, 2'b11, 1'b1, 16'd3);
    issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'd3);
    flush();

    for (int n = 0; n < 400; n++) begin
      wa = rand_addr();
      ra = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
      issue(1'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), ra);
    end
    flush();

    apply_reset(1, 4);
    for (int a = 0; a < DEPTH; a++) issue(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'(a));
    for (int n = 0; n < 100; n++) begin
      wa = rand_addr();
      ra = ($urandom_range(0, 2) == 0) ? wa : rand_addr();
      issue(1'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), ra);
    end
    flush();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
